// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load plus multi-step rotate/shift operations run by an IDLE/RUN FSM.
// Define UNIVERSAL_SHIFT_REG_BARREL_EN to apply the whole step count in a single RUN edge (barrel).
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ParallelLoadn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] Data_IN,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       mode_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             so_q;
  logic             done_q;

  logic [WIDTH-1:0] q_d;
  logic             so_d;

  // One single-bit step; result is {bit_out, new_word}. Hold modes keep the previous bit_out.
  function automatic logic [WIDTH:0] step1(
    input logic [WIDTH-1:0] q,
    input logic [2:0]       m,
    input logic             sin,
    input logic             so
  );
    logic [WIDTH:0] r;
    r = {so, q};
    case (m)
      3'b001:  r = {q[0], q[0], q[WIDTH-1:1]};
      3'b010:  r = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
      3'b011:  r = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
      3'b100:  r = {q[0], sin, q[WIDTH-1:1]};
      3'b101:  r = {q[WIDTH-1], q[WIDTH-2:0], sin};
      default: r = {so, q};
    endcase
    return r;
  endfunction

`ifdef UNIVERSAL_SHIFT_REG_BARREL_EN
  localparam int MAX_STEPS = (1 << AMT_W) - 1;

  // Unrolled chain of single steps, gated by the latched count.
  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    for (int i = 0; i < MAX_STEPS; i++) begin
      if (i < int'(cnt_q)) begin
        {so_d, q_d} = step1(q_d, mode_q, serial_in, so_d);
      end
    end
  end
`else
  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    {so_d, q_d} = step1(q_q, mode_q, serial_in, so_q);
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 3'b000;
      cnt_q   <= '0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!ParallelLoadn) begin
        q_q     <= Data_IN;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (amount == '0) begin
                done_q <= 1'b1;
              end else begin
                mode_q  <= mode;
                cnt_q   <= amount;
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            q_q  <= q_d;
            so_q <= so_d;
`ifdef UNIVERSAL_SHIFT_REG_BARREL_EN
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b1;
`else
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == AMT_W'(1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Q          = q_q;
  assign serial_out = so_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8); step-count expectations follow the barrel macro.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             ParallelLoadn;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] Data_IN;
  logic             serial_in;
  logic [WIDTH-1:0] Q;
  logic             serial_out;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;
  int steps;
  int done_seen;

  universal_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .ParallelLoadn(ParallelLoadn),
    .start        (start),
    .mode         (mode),
    .amount       (amount),
    .Data_IN      (Data_IN),
    .serial_in    (serial_in),
    .Q            (Q),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] d);
    ParallelLoadn = 1'b0;
    Data_IN = d;
    tick();
    ParallelLoadn = 1'b1;
  endtask

  // Start an operation and count step edges until done; -1 if done never arrives.
  task automatic do_op(input logic [2:0] m, input logic [AMT_W-1:0] a, output int n);
    mode = m;
    amount = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int exp_steps(input int a);
`ifdef UNIVERSAL_SHIFT_REG_BARREL_EN
    return 1;
`else
    return a;
`endif
  endfunction

  initial begin
    reset = 1'b1;
    ParallelLoadn = 1'b1;
    start = 1'b0;
    mode = 3'b000;
    amount = '0;
    Data_IN = '0;
    serial_in = 1'b0;
    #3;
    chk("rst_q", Q, 0);
    chk("rst_so", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();

    // rotate right 0xA5 by 3
    load(8'hA5);
    chk("load_q", Q, 8'hA5);
    mode = 3'b001;
    amount = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ror_start_busy", busy, 1);
    chk("ror_start_q", Q, 8'hA5);
    steps = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done) begin
        steps = i;
        break;
      end
    end
    chk("ror3_steps", steps, exp_steps(3));
    chk("ror3_q", Q, 8'hB4);
    chk("ror3_so", serial_out, 1);
    chk("ror3_busy_end", busy, 0);
    tick();
    chk("ror3_done_1cyc", done, 0);

    // arithmetic right 0x90 by 2
    load(8'h90);
    do_op(3'b011, 4'd2, steps);
    chk("asr2_steps", steps, exp_steps(2));
    chk("asr2_q", Q, 8'hE4);
    chk("asr2_so", serial_out, 0);

    // logical left fill with ones, 8 steps
    load(8'h00);
    serial_in = 1'b1;
    do_op(3'b101, 4'd8, steps);
    chk("lsl8_steps", steps, exp_steps(8));
    chk("lsl8_q", Q, 8'hFF);
    chk("lsl8_so", serial_out, 0);
    tick();
    chk("lsl8_done_once", done, 0);
    serial_in = 1'b0;

    // load aborts a rotate-left in progress
    load(8'h81);
    mode = 3'b010;
    amount = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifndef UNIVERSAL_SHIFT_REG_BARREL_EN
    tick();
    tick();
    chk("rol_mid_q", Q, 8'h06);
`endif
    load(8'h3C);
    chk("abort_q", Q, 8'h3C);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    // zero amount completes on the start edge
    mode = 3'b001;
    amount = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("amt0_done", done, 1);
    chk("amt0_q", Q, 8'h3C);
    chk("amt0_busy", busy, 0);
    tick();
    chk("amt0_done_1cyc", done, 0);

    // rotate left 1, then logical right with ones fill
    do_op(3'b010, 4'd1, steps);
    chk("rol1_q", Q, 8'h78);
    serial_in = 1'b1;
    do_op(3'b100, 4'd4, steps);
    chk("lsr4_steps", steps, exp_steps(4));
    chk("lsr4_q", Q, 8'hF7);
    chk("lsr4_so", serial_out, 1);
    serial_in = 1'b0;

    // hold modes run their count without touching Q or serial_out
    do_op(3'b000, 4'd3, steps);
    chk("hold_steps", steps, exp_steps(3));
    chk("hold_q", Q, 8'hF7);
    chk("hold_so", serial_out, 1);
    do_op(3'b110, 4'd2, steps);
    chk("hold110_steps", steps, exp_steps(2));
    chk("hold110_q", Q, 8'hF7);

    // rotation beyond WIDTH wraps
    load(8'hA5);
    do_op(3'b001, 4'd11, steps);
    chk("ror11_steps", steps, exp_steps(11));
    chk("ror11_q", Q, 8'hB4);
    chk("ror11_so", serial_out, 1);

    // arithmetic shift beyond WIDTH saturates to sign
    load(8'h80);
    do_op(3'b011, 4'd15, steps);
    chk("asr15_steps", steps, exp_steps(15));
    chk("asr15_q", Q, 8'hFF);
    chk("asr15_so", serial_out, 1);

    // reset mid-RUN abandons the operation
    load(8'h5A);
    mode = 3'b001;
    amount = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_q", Q, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_so", serial_out, 0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    chk("post_rst_idle", done_seen, 0);
    chk("post_rst_q", Q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
